// File: rtl/writeback_arbiter.sv
// Arbitrates ALU (A) and load (B) writebacks onto the single register-file write port.
// Define WB_ARB_STARVE_GUARD_EN to enable the port-B starvation boost (PRIO_B state).
module writeback_arbiter #(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  a_valid,
    input  logic [4:0]            a_reg,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [4:0]            b_reg,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_ready,
    output logic                  write,
    output logic [4:0]            write_reg,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  b_boosted,
    input  logic                  report
);

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } state_e;

    state_e                state_q;
    logic [3:0]            starve_q;
    logic                  a_xfer;
    logic                  b_xfer;
    logic                  write_q, write_d;
    logic [4:0]            write_reg_q, write_reg_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
    logic [31:0]           cycles_q;

`ifdef WB_ARB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_e     state_d;
    logic [3:0] starve_d;
    logic       b_boosted_q;

    always_comb begin
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        state_d  = state_q;
        starve_d = starve_q;
        if (!reset) begin
            unique case (state_q)
                PRIO_A: begin
                    a_ready = a_valid;
                    b_ready = b_valid & ~a_valid;
                end
                PRIO_B: begin
                    b_ready = b_valid;
                    a_ready = a_valid & ~b_valid;
                end
            endcase
        end
        if (b_valid && b_ready) begin
            starve_d = 4'd0;
            state_d  = PRIO_A;
        end else if (b_valid) begin
            if (starve_q != 4'hf) starve_d = starve_q + 4'd1;
            if (state_q == PRIO_A && starve_d == LIMIT) state_d = PRIO_B;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= PRIO_A;
            starve_q    <= 4'd0;
            b_boosted_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            b_boosted_q <= (state_d == PRIO_B);
        end
    end

    assign b_boosted = b_boosted_q;
`else
    // Fixed priority: A always wins, no starvation tracking.
    assign a_ready   = ~reset & a_valid;
    assign b_ready   = ~reset & b_valid & ~a_valid;
    assign state_q   = PRIO_A;
    assign starve_q  = 4'd0;
    assign b_boosted = 1'b0;
`endif

    assign a_xfer = a_valid & a_ready;
    assign b_xfer = b_valid & b_ready;

    always_comb begin
        write_d      = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        if (b_xfer) begin
            write_d      = (b_reg != 5'd0);
            write_reg_d  = b_reg;
            write_data_d = b_data;
        end else if (a_xfer) begin
            write_d      = (a_reg != 5'd0);
            write_reg_d  = a_reg;
            write_data_d = a_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            write_q      <= 1'b0;
            write_reg_q  <= 5'd0;
            write_data_q <= '0;
            cycles_q     <= 32'd0;
        end else begin
            write_q      <= write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            cycles_q     <= cycles_q + 32'd1;
        end
    end

    assign write      = write_q;
    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (report) begin
            $display("core=%0d cyc=%0d state=%s starve=%0d/%0d a=%b/%b b=%b/%b wr=%b reg=%0d data=%h",
                     CORE, cycles_q, state_q.name(), starve_q, STARVE_LIMIT,
                     a_valid, a_ready, b_valid, b_ready,
                     write_q, write_reg_q, write_data_q);
        end
    end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized self-checking bench for writeback_arbiter against a transaction-level model.
// Follows WB_ARB_STARVE_GUARD_EN to pick the expected arbitration policy.
module tb_writeback_arbiter;

    localparam int DW  = 32;
    localparam int LIM = 4;
`ifdef WB_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          a_valid, b_valid, a_ready, b_ready;
    logic [4:0]    a_reg, b_reg, write_reg;
    logic [DW-1:0] a_data, b_data, write_data;
    logic          write, b_boosted, report;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    writeback_arbiter #(
        .CORE(0), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)
    ) dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
        .write(write), .write_reg(write_reg), .write_data(write_data),
        .b_boosted(b_boosted), .report(report)
    );

    // Model: who wins is decided by whether B has been refused often enough.
    bit            m_boost;
    int            m_starve;
    logic          m_write;
    logic [4:0]    m_reg;
    logic [DW-1:0] m_data;

    function automatic logic win_a();
        return !reset && a_valid && !(m_boost && b_valid);
    endfunction

    function automatic logic win_b();
        return !reset && b_valid && (!a_valid || m_boost);
    endfunction

    task automatic model_edge();
        logic wa, wb;
        wa = win_a();
        wb = win_b();
        if (reset) begin
            m_boost = 0; m_starve = 0;
            m_write = 0; m_reg = 0; m_data = 0;
            return;
        end
        m_write = 0;
        if (wa) begin
            m_write = (a_reg != 0); m_reg = a_reg; m_data = a_data;
        end
        if (wb) begin
            m_write = (b_reg != 0); m_reg = b_reg; m_data = b_data;
            m_starve = 0;
            m_boost = 0;
        end else if (b_valid) begin
            if (m_starve < 15) m_starve++;
            if (GUARD && m_starve == LIM) m_boost = 1;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; report = 0;
        a_valid = 1; a_reg = 3; a_data = 32'h11;
        b_valid = 1; b_reg = 4; b_data = 32'h22;
        tick();
        tick();
        @(negedge clock);
        n_cmp++; if (a_ready !== 1'b0) begin n_bad++; $display("FAIL rst_a_ready got %b want 0", a_ready); end
        n_cmp++; if (b_ready !== 1'b0) begin n_bad++; $display("FAIL rst_b_ready got %b want 0", b_ready); end
        n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL rst_write got %b want 0", write); end
        n_cmp++; if (write_reg !== 5'd0) begin n_bad++; $display("FAIL rst_write_reg got %0d want 0", write_reg); end
        n_cmp++; if (write_data !== '0) begin n_bad++; $display("FAIL rst_write_data got %h want 0", write_data); end
        n_cmp++; if (b_boosted !== 1'b0) begin n_bad++; $display("FAIL rst_boost got %b want 0", b_boosted); end
        reset = 0; a_valid = 0; b_valid = 0;
        tick();
    endtask

    task automatic test_single_a();
        a_valid = 1; a_reg = 5; a_data = 32'h1234;
        report = 1;
        @(negedge clock);
        n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL single_a_ready got %b want 1", a_ready); end
        tick();
        a_valid = 0; report = 0;
        @(negedge clock);
        n_cmp++; if (write !== 1'b1) begin n_bad++; $display("FAIL single_write got %b want 1", write); end
        n_cmp++; if (write_reg !== 5'd5) begin n_bad++; $display("FAIL single_reg got %0d want 5", write_reg); end
        n_cmp++; if (write_data !== 32'h1234) begin n_bad++; $display("FAIL single_data got %h want 1234", write_data); end
        tick();
        @(negedge clock);
        n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL single_write_n2 got %b want 0", write); end
        tick();
    endtask

    task automatic test_contention();
        logic       exp_b;
        logic [4:0] exp_reg;
        exp_reg = 0;
        a_valid = 1; a_reg = 1; a_data = 32'hA000_0001;
        b_valid = 1; b_reg = 7; b_data = 32'hBEEF;
        for (int i = 0; i < 20; i++) begin
            exp_b = GUARD && (i % (LIM + 1) == LIM);
            @(negedge clock);
            n_cmp++; if (b_ready !== exp_b) begin n_bad++; $display("FAIL cont_b_ready i=%0d got %b want %b", i, b_ready, exp_b); end
            n_cmp++; if (a_ready !== !exp_b) begin n_bad++; $display("FAIL cont_a_ready i=%0d got %b want %b", i, a_ready, !exp_b); end
            n_cmp++; if (b_boosted !== exp_b) begin n_bad++; $display("FAIL cont_boost i=%0d got %b want %b", i, b_boosted, exp_b); end
            if (i > 0) begin
                n_cmp++; if (write_reg !== exp_reg) begin n_bad++; $display("FAIL cont_reg i=%0d got %0d want %0d", i, write_reg, exp_reg); end
            end
            exp_reg = exp_b ? 5'd7 : a_reg;
            tick();
            if (!exp_b) begin
                a_reg = a_reg + 1;
                a_data = a_data + 1;
            end
        end
        a_valid = 0; b_valid = 0;
        tick();
    endtask

    task automatic test_x0();
        b_valid = 1; b_reg = 0; b_data = 32'hFFFF;
        @(negedge clock);
        n_cmp++; if (b_ready !== 1'b1) begin n_bad++; $display("FAIL x0_b_ready got %b want 1", b_ready); end
        tick();
        b_valid = 0;
        @(negedge clock);
        n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL x0_write got %b want 0", write); end
        n_cmp++; if (write_data !== 32'hFFFF) begin n_bad++; $display("FAIL x0_data got %h want ffff", write_data); end
        tick();
    endtask

    task automatic test_mid_reset();
        logic exp_b;
        a_valid = 1; a_reg = 9; a_data = 32'h99;
        b_valid = 1; b_reg = 12; b_data = 32'hCC;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL mrst_pre_a i=%0d got %b want 1", i, a_ready); end
            tick();
        end
        reset = 1;
        @(negedge clock);
        n_cmp++; if ({a_ready, b_ready} !== 2'b00) begin n_bad++; $display("FAIL mrst_ready got %b want 00", {a_ready, b_ready}); end
        tick();
        reset = 0;
        for (int i = 0; i < 5; i++) begin
            exp_b = GUARD && (i == LIM);
            @(negedge clock);
            if (i == 0) begin
                n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL mrst_write got %b want 0", write); end
            end
            n_cmp++; if (b_ready !== exp_b) begin n_bad++; $display("FAIL mrst_b_ready i=%0d got %b want %b", i, b_ready, exp_b); end
            tick();
        end
        a_valid = 0; b_valid = 0;
        tick();
    endtask

    task automatic test_random();
        logic wa, wb;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            wa = win_a();
            wb = win_b();
            n_cmp++; if (a_ready !== wa) begin n_bad++; $display("FAIL rnd_a_ready i=%0d got %b want %b", i, a_ready, wa); end
            n_cmp++; if (b_ready !== wb) begin n_bad++; $display("FAIL rnd_b_ready i=%0d got %b want %b", i, b_ready, wb); end
            n_cmp++; if (write !== m_write) begin n_bad++; $display("FAIL rnd_write i=%0d got %b want %b", i, write, m_write); end
            n_cmp++; if (write_reg !== m_reg) begin n_bad++; $display("FAIL rnd_reg i=%0d got %0d want %0d", i, write_reg, m_reg); end
            n_cmp++; if (write_data !== m_data) begin n_bad++; $display("FAIL rnd_data i=%0d got %h want %h", i, write_data, m_data); end
            n_cmp++; if (b_boosted !== logic'(m_boost)) begin n_bad++; $display("FAIL rnd_boost i=%0d got %b want %b", i, b_boosted, m_boost); end
            tick();
            reset = ($urandom_range(0, 60) == 0);
            if (wa || !a_valid) begin
                a_valid = ($urandom_range(0, 3) != 0);
                a_reg = 5'($urandom);
                a_data = $urandom;
            end
            if (wb || !b_valid) begin
                b_valid = ($urandom_range(0, 2) != 0);
                b_reg = 5'($urandom);
                b_data = $urandom;
            end
        end
        reset = 0; a_valid = 0; b_valid = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_contention();
        test_x0();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
